// File: rtl/tiling_pkg.sv
// Shared tiling definitions: default frame geometry, derived tile counts,
// write-back FSM state encoding and the coordinate counter type.
package tiling_pkg;

  localparam int unsigned DEF_IMAGE_WIDTH  = 640;
  localparam int unsigned DEF_IMAGE_HEIGHT = 480;
  localparam int unsigned DEF_TILE_SIZE    = 16;

  localparam int unsigned TILES_X = DEF_IMAGE_WIDTH  / DEF_TILE_SIZE;
  localparam int unsigned TILES_Y = DEF_IMAGE_HEIGHT / DEF_TILE_SIZE;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef logic [CNT_W-1:0] coord_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE_TILE,
    S_NEXT_TILE,
    S_DONE
  } wb_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Maps a (tile, pixel-in-tile) coordinate to a raster-order frame address.
// Purely combinational so read- and write-side tiling logic can share it.
module tile_addr_gen
  import tiling_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int unsigned TILE_SIZE   = DEF_TILE_SIZE
) (
  input  coord_t              i_tile_x,
  input  coord_t              i_tile_y,
  input  coord_t              i_pixel_x,
  input  coord_t              i_pixel_y,
  output logic [ADDR_W-1:0]   o_addr
);

  // 32-bit intermediate math, truncated to the BRAM address width at the end.
  always_comb begin
    o_addr = ADDR_W'((32'(i_tile_y) * TILE_SIZE + 32'(i_pixel_y)) * IMAGE_WIDTH
                     + 32'(i_tile_x) * TILE_SIZE + 32'(i_pixel_x));
  end

endmodule

// File: rtl/tile_writeback.sv
// Accepts a frame of pixels in tile order and writes each one to its raster
// address in BRAM, one registered write per accepted beat.
module tile_writeback
  import tiling_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int unsigned TILE_SIZE    = DEF_TILE_SIZE
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [DATA_W-1:0] i_tile_data,
  input  logic              i_tile_data_valid,
  output logic              o_tile_ready,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_bram_we,
  output logic              o_busy,
  output logic              o_done
);

  localparam coord_t L_PIX_LAST = coord_t'(TILE_SIZE - 1);
  localparam coord_t L_TX_LAST  = coord_t'(IMAGE_WIDTH / TILE_SIZE - 1);
  localparam coord_t L_TY_LAST  = coord_t'(IMAGE_HEIGHT / TILE_SIZE - 1);

  wb_state_t         r_state;
  coord_t            r_tile_x;
  coord_t            r_tile_y;
  coord_t            r_pix_x;
  coord_t            r_pix_y;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_wdata;
  logic              r_bram_we;
  logic              r_done;

  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;

  tile_addr_gen #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .TILE_SIZE   (TILE_SIZE)
  ) u_addr_gen (
    .i_tile_x  (r_tile_x),
    .i_tile_y  (r_tile_y),
    .i_pixel_x (r_pix_x),
    .i_pixel_y (r_pix_y),
    .o_addr    (w_addr)
  );

  always_comb begin
    o_tile_ready = (r_state == S_WRITE_TILE);
    o_busy       = (r_state != S_IDLE);
    w_accept     = i_tile_data_valid && (r_state == S_WRITE_TILE);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state      <= S_IDLE;
      r_tile_x     <= '0;
      r_tile_y     <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_bram_we    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_bram_we <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_tile_x <= '0;
            r_tile_y <= '0;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
            r_state  <= S_WRITE_TILE;
          end
        end
        S_WRITE_TILE: begin
          if (w_accept) begin
            r_bram_we    <= 1'b1;
            r_bram_addr  <= w_addr;
            r_bram_wdata <= i_tile_data;
            if (r_pix_x == L_PIX_LAST) begin
              r_pix_x <= '0;
              if (r_pix_y == L_PIX_LAST) begin
                r_state <= S_NEXT_TILE;
              end else begin
                r_pix_y <= r_pix_y + 1'b1;
              end
            end else begin
              r_pix_x <= r_pix_x + 1'b1;
            end
          end
        end
        S_NEXT_TILE: begin
          r_pix_x <= '0;
          r_pix_y <= '0;
          r_state <= S_WRITE_TILE;
          if (r_tile_x == L_TX_LAST) begin
            r_tile_x <= '0;
            if (r_tile_y == L_TY_LAST) begin
              // o_done is registered, so it is raised on the edge entering S_DONE.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_tile_y <= r_tile_y + 1'b1;
            end
          end else begin
            r_tile_x <= r_tile_x + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_bram_addr  = r_bram_addr;
    o_bram_wdata = r_bram_wdata;
    o_bram_we    = r_bram_we;
    o_done       = r_done;
  end

endmodule

// File: tb/tb_tile_writeback.sv
// Self-checking bench for tile_writeback on a reduced 128x64 frame.
module tb_tile_writeback;

  localparam int W     = 128;
  localparam int H     = 64;
  localparam int T     = 16;
  localparam int TX    = W / T;
  localparam int TY    = H / T;
  localparam int NPIX  = W * H;
  localparam int LIMIT = 40000;

  logic        iClk;
  logic        iRst;
  logic        iStart;
  logic [7:0]  i_tile_data;
  logic        i_tile_data_valid;
  logic        o_tile_ready;
  logic [18:0] o_bram_addr;
  logic [7:0]  o_bram_wdata;
  logic        o_bram_we;
  logic        o_busy;
  logic        o_done;

  tile_writeback #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .TILE_SIZE    (T)
  ) dut (
    .iClk              (iClk),
    .iRst              (iRst),
    .iStart            (iStart),
    .i_tile_data       (i_tile_data),
    .i_tile_data_valid (i_tile_data_valid),
    .o_tile_ready      (o_tile_ready),
    .o_bram_addr       (o_bram_addr),
    .o_bram_wdata      (o_bram_wdata),
    .o_bram_we         (o_bram_we),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    int          beat;
    logic [18:0] addr;
    logic [7:0]  data;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  int          cyc = 0;
  int          beat, nwr, ndone, nstall, done_cyc;
  logic        acc_prev;
  logic [18:0] exp_addr, hold_addr, last_addr;
  logic [7:0]  exp_data, hold_data;
  logic [18:0] wr_addr [NPIX];
  logic [7:0]  wr_data [NPIX];
  int          acc_cyc [NPIX];
  vec_t        vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: beat index -> raster address, straight from the tiling order.
  function automatic logic [18:0] model_addr(input int k);
    int tile, w, tx, ty;
    tile = k / (T * T);
    w    = k % (T * T);
    tx   = tile % TX;
    ty   = tile / TX;
    return 19'((ty * T + w / T) * W + tx * T + w % T);
  endfunction

  task automatic mon();
    cyc++;
    if (!iRst) begin
      acc_prev  = 1'b0;
      hold_addr = '0;
      hold_data = '0;
      return;
    end
    chk("we", o_bram_we, acc_prev);
    if (acc_prev) begin
      chk("addr", o_bram_addr, exp_addr);
      chk("wdata", o_bram_wdata, exp_data);
      if (nwr < NPIX) begin
        wr_addr[nwr] = o_bram_addr;
        wr_data[nwr] = o_bram_wdata;
      end
      nwr++;
      last_addr = o_bram_addr;
      hold_addr = exp_addr;
      hold_data = exp_data;
    end else begin
      chk("hold_addr", o_bram_addr, hold_addr);
      chk("hold_wdata", o_bram_wdata, hold_data);
    end
    if (o_done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (o_busy && !o_tile_ready && !o_done) nstall++;
    acc_prev = i_tile_data_valid && o_tile_ready;
    if (acc_prev) begin
      exp_addr = model_addr(beat);
      exp_data = i_tile_data;
      if (beat < NPIX) acc_cyc[beat] = cyc;
      beat++;
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    mon();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    o_bram_we,    0);
    chk({tag, "_addr"},  o_bram_addr,  0);
    chk({tag, "_wdata"}, o_bram_wdata, 0);
    chk({tag, "_done"},  o_done,       0);
    chk({tag, "_busy"},  o_busy,       0);
    chk({tag, "_ready"}, o_tile_ready, 0);
  endtask

  task automatic run_frame(input int duty, input bit hold_start, input int rst_at, input bit det);
    int n, c0, nwr_before;
    beat = 0; nwr = 0; ndone = 0; nstall = 0; done_cyc = 0;
    iStart = 1'b1;
    c0 = cyc + 1;
    tick();
    iStart = hold_start;
    n = 0;
    while (ndone == 0 && n < LIMIT) begin
      if (rst_at >= 0 && beat == rst_at) begin
        iRst = 1'b0;
        #1;
        chk_all_zero("midrst");
        nwr_before = nwr;
        i_tile_data_valid = 1'b1;
        repeat (3) tick();
        iRst = 1'b1;
        repeat (5) tick();
        chk("midrst_nowrites", nwr, nwr_before);
        chk("midrst_idle", o_busy, 0);
        return;
      end
      i_tile_data_valid = (int'($urandom_range(0, 99)) < duty);
      i_tile_data = det ? ((beat == 0) ? 8'hA5 : (8'(beat) ^ 8'h5A)) : 8'($urandom);
      tick();
      n++;
    end
    chk("frame_timeout", (n < LIMIT), 1);
    iStart = 1'b0;
    i_tile_data_valid = 1'b0;
    tick();
    chk("post_busy", o_busy, 0);
    chk("post_ready", o_tile_ready, 0);
    chk("post_done", o_done, 0);
    chk("done_pulses", ndone, 1);
    chk("write_count", nwr, NPIX);
    chk("last_addr", last_addr, NPIX - 1);
    chk("tile_stalls", nstall, TX * TY);
    if (duty >= 100)
      chk("frame_cycles", (done_cyc - c0 >= NPIX + TX * TY) && (done_cyc - c0 <= NPIX + TX * TY + 3), 1);
  endtask

  initial begin
    vecs[0] = '{0,    19'd0,    8'hA5};
    vecs[1] = '{1,    19'd1,    8'h5B};
    vecs[2] = '{15,   19'd15,   8'h55};
    vecs[3] = '{16,   19'd128,  8'h4A};
    vecs[4] = '{255,  19'd1935, 8'hA5};
    vecs[5] = '{256,  19'd16,   8'h5A};
    vecs[6] = '{272,  19'd144,  8'h4A};
    vecs[7] = '{2048, 19'd2048, 8'h5A};
    vecs[8] = '{8191, 19'd8191, 8'hA5};

    iRst = 1'b0; iStart = 1'b0; i_tile_data = '0; i_tile_data_valid = 1'b0;
    acc_prev = 1'b0; hold_addr = '0; hold_data = '0; last_addr = '0;
    exp_addr = '0; exp_data = '0;
    beat = 0; nwr = 0; ndone = 0; nstall = 0; done_cyc = 0;
    #12;
    chk_all_zero("reset");
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    i_tile_data_valid = 1'b1;
    repeat (3) tick();
    chk("idle_ignores_valid", nwr, 0);

    // Continuous stream with known data, then table of spot positions.
    run_frame(100, 1'b0, -1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl_addr[%0d]", vecs[i].beat), wr_addr[vecs[i].beat], vecs[i].addr);
      chk($sformatf("tbl_data[%0d]", vecs[i].beat), wr_data[vecs[i].beat], vecs[i].data);
    end
    chk("stream_gap_in_tile", acc_cyc[255] - acc_cyc[254], 1);
    chk("tile_boundary_gap", acc_cyc[256] - acc_cyc[255], 2);

    run_frame(50, 1'b0, -1, 1'b0);
    // iStart held high for the whole frame, including the S_DONE cycle.
    run_frame(70, 1'b1, -1, 1'b0);
    run_frame(100, 1'b0, 1000, 1'b0);
    run_frame(100, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tile_writeback.md
TILE_WRITEBACK -- requirements
Module: tile_writeback

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, image width in pixels.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, image height in pixels.
REQ-003 SHALL have parameter TILE_SIZE, default 16, tile edge in pixels; IMAGE_WIDTH and IMAGE_HEIGHT are integer multiples of it.
REQ-004 SHALL have port iClk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port iRst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iStart  input  1  one-cycle request to begin writing one frame.
REQ-007 SHALL have port i_tile_data  input  8  pixel arriving in tile order.
REQ-008 SHALL have port i_tile_data_valid  input  1  i_tile_data is valid this cycle.
REQ-009 SHALL have port o_tile_ready  output  1  block accepts a pixel this cycle.
REQ-010 SHALL have port o_bram_addr  output  19  raster write address.
REQ-011 SHALL have port o_bram_wdata  output  8  write data.
REQ-012 SHALL have port o_bram_we  output  1  write enable, one cycle per pixel.
REQ-013 SHALL have port o_busy  output  1  frame in progress.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse after the last frame pixel is written.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_WRITE_TILE, S_NEXT_TILE, S_DONE.
REQ-016 S_IDLE -> S_WRITE_TILE on iStart; tile and pixel counters cleared on entry.
REQ-017 o_tile_ready SHALL be 1 only in S_WRITE_TILE, combinationally from state.
REQ-018 A beat is accepted when i_tile_data_valid and o_tile_ready are both 1; valid with ready low is ignored, nothing consumed.
REQ-019 Accepted beat order: pixel_x fastest (0..TILE_SIZE-1), then pixel_y, inside a tile; tiles ordered tile_x fastest (0..IMAGE_WIDTH/TILE_SIZE-1), then tile_y.
REQ-020 On accepted beat in cycle N, cycle N+1 SHALL show o_bram_we=1, o_bram_wdata=beat data, o_bram_addr=(tile_y*TILE_SIZE+pixel_y)*IMAGE_WIDTH+tile_x*TILE_SIZE+pixel_x; o_bram_we=0 in all other cycles.
REQ-021 Address math SHALL be done at full width, result truncated to 19 bits; o_bram_addr and o_bram_wdata hold last value when o_bram_we=0.
REQ-022 Pixel counters advance only on accepted beats; idle cycles (valid low) insert no writes and lose no position.
REQ-023 Accepting pixel (TILE_SIZE-1, TILE_SIZE-1) SHALL move S_WRITE_TILE -> S_NEXT_TILE (ready low for exactly that one cycle).
REQ-024 S_NEXT_TILE SHALL clear pixel counters, advance tile counters (tile_x wraps to 0 and tile_y increments), and go to S_WRITE_TILE, unless the finished tile was the last tile, then go to S_DONE.
REQ-025 S_DONE SHALL last one cycle, assert o_done=1 (registered, that cycle only), then return to S_IDLE.
REQ-026 o_busy SHALL be 1 in S_WRITE_TILE, S_NEXT_TILE, S_DONE; 0 in S_IDLE.
REQ-027 iStart while o_busy=1 SHALL be ignored; iStart in the S_DONE cycle is ignored.
REQ-028 The final write (address IMAGE_WIDTH*IMAGE_HEIGHT-1) SHALL occur no later than the o_done cycle.

Reset
REQ-029 On iRst low, asynchronously: state=S_IDLE, all counters 0, o_bram_addr=0, o_bram_wdata=0, o_bram_we=0, o_done=0; o_busy and o_tile_ready therefore 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no further writes; a new iStart restarts from tile (0,0).

Structure
REQ-031 A shared package tiling_pkg SHALL hold the FSM state encoding, default IMAGE_WIDTH/IMAGE_HEIGHT/TILE_SIZE, and derived tile counts (TILES_X=40, TILES_Y=30).
REQ-032 Coordinate-to-address computation SHALL be one sub-module tile_addr_gen (tile_x, tile_y, pixel_x, pixel_y -> 19-bit address), reusable by the read-side tiling logic.

Verification
REQ-033 Reset, iStart, continuous valid: first beat 0xA5 -> next cycle we=1, addr=0, wdata=0xA5; 16th beat -> addr=15; 17th beat -> addr=640.
REQ-034 Tile boundary: after 256 beats ready=0 for one cycle; beat 257 -> addr=16; first beat of tile (0,1) -> addr=10240.
REQ-035 Full frame 307200 beats: last write addr=307199, o_done pulses once, o_busy falls, exactly 307200 we pulses, total cycles = 307200 + 1200 + small constant.
REQ-036 Random valid gaps (about 50% duty): address sequence identical to REQ-035, no write in gap cycles.
REQ-037 iStart pulsed mid-frame: ignored, sequence unchanged; reset asserted at beat 1000: all outputs 0 immediately, no write until new iStart, which restarts at addr=0.
